ahbl_uart_rx: RTL and testbench

AHB-Lite slave UART receiver: 8N1 serial input with 16x oversampling, programmable baud prescaler, receive FIFO, sticky error flags and a level interrupt. It is the receive-side counterpart of the UART transmitter. It occupies a slave port on the AHB-Lite crossbar, alongside the transmitter's region, so the CPU or the DMAC can drain received bytes.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/ahbl_uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_ahbl_uart_rx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the AHB-Lite UART receiver: register map, STATUS layout,
// oversampling points and the receive FSM state encoding.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 7;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. A pop frees a slot in the same cycle, so a push
// into a full FIFO alongside a pop is accepted.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    import uart_rx_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1, 16x oversampling off a programmable prescaler,
// receive FIFO with sticky overrun/frame flags and a thresholded level IRQ.
module ahbl_uart_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic        rx,
    output logic        IRQ
);
    import uart_rx_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             valid_q, wr_q;
    logic [1:0]       addr_q;
    logic [DIV_W-1:0] div_q, presc_q, presc_d;
    logic             en_q, irq_en_q, ovr_q, ferr_q;
    logic [5:0]       thresh_q;
    logic             sync1_q, sync2_q, rx_s, tick;
    rx_state_e        state_q, state_d;
    logic [3:0]       os_q, os_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_push, ferr_set, ovr_set, rd_act, wr_act, data_pop;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             unused_bits;

    assign unused_bits = ^{HSIZE, HADDR, HTRANS[0], HWDATA};
    assign HREADYOUT   = 1'b1;
    assign rd_act      = valid_q & ~wr_q;
    assign wr_act      = valid_q & wr_q;
    assign data_pop    = rd_act & (addr_q == ADDR_DATA) & ~fifo_empty;
    assign ovr_set     = rx_push & fifo_full & ~data_pop;
    assign rx_s        = sync2_q;
    assign tick        = (presc_q == '0);
    assign presc_d     = tick ? div_q : presc_q - 1'b1;
    assign IRQ         = irq_en_q & (7'(fifo_count) > {1'b0, thresh_q});

    // Bus address phase, control registers, prescaler and synchronizer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            div_q    <= '0;
            presc_q  <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
        end else begin
            valid_q <= HSEL & HREADY & HTRANS[1];
            if (HSEL & HREADY & HTRANS[1]) begin
                wr_q   <= HWRITE;
                addr_q <= HADDR[3:2];
            end
            presc_q <= presc_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            if (wr_act && addr_q == ADDR_DIV) div_q <= HWDATA[DIV_W-1:0];
            if (wr_act && addr_q == ADDR_CTRL) begin
                en_q     <= HWDATA[0];
                irq_en_q <= HWDATA[1];
                thresh_q <= HWDATA[9:4];
            end
            // A new error in the same cycle as a clear wins, so it is not lost.
            if (wr_act && addr_q == ADDR_STATUS && HWDATA[ST_OVERRUN])   ovr_q  <= 1'b0;
            if (wr_act && addr_q == ADDR_STATUS && HWDATA[ST_FRAME_ERR]) ferr_q <= 1'b0;
            if (ovr_set)  ovr_q  <= 1'b1;
            if (ferr_set) ferr_q <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= RX_IDLE;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_q) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE:  if (!rx_s) state_d = RX_START;
                RX_START: if (tick && os_q == OS_MID) state_d = rx_s ? RX_IDLE : RX_DATA;
                RX_DATA:  if (tick && os_q == OS_LAST && bit_q == 3'd7) state_d = RX_STOP;
                RX_STOP:  if (tick && os_q == OS_LAST) state_d = RX_IDLE;
                default:  state_d = RX_IDLE;
            endcase
        end
    end

    // The 4-bit oversample counter wraps 15->0 on its own between data samples.
    always_comb begin
        os_d     = os_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                os_d  = '0;
                bit_d = '0;
            end
            RX_START: if (tick) os_d = (os_q == OS_MID) ? 4'd0 : os_q + 4'd1;
            RX_DATA: if (tick) begin
                os_d = os_q + 4'd1;
                if (os_q == OS_LAST) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                end
            end
            RX_STOP: if (tick) begin
                os_d = os_q + 4'd1;
                if (os_q == OS_LAST) begin
                    rx_push  = en_q & rx_s;
                    ferr_set = en_q & ~rx_s;
                end
            end
            default: os_d = '0;
        endcase
    end

    always_comb begin
        HRDATA = '0;
        if (rd_act) begin
            case (addr_q)
                ADDR_DATA:   HRDATA[7:0] = fifo_empty ? 8'h00 : fifo_dout;
                ADDR_STATUS: begin
                    HRDATA[ST_NOT_EMPTY] = ~fifo_empty;
                    HRDATA[ST_FULL]      = fifo_full;
                    HRDATA[ST_OVERRUN]   = ovr_q;
                    HRDATA[ST_FRAME_ERR] = ferr_q;
                    HRDATA[ST_COUNT_LSB +: ST_COUNT_W] = 7'(fifo_count);
                end
                ADDR_DIV:    HRDATA[DIV_W-1:0] = div_q;
                default: begin
                    HRDATA[0]   = en_q;
                    HRDATA[1]   = irq_en_q;
                    HRDATA[9:4] = thresh_q;
                end
            endcase
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .push_i  (rx_push),
        .pop_i   (data_pop),
        .din_i   (sh_q),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Bench for ahbl_uart_rx: drives UART frames on rx and AHB-Lite register
// accesses, and checks against a queue-based model of the receiver.
module tb_ahbl_uart_rx;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, rx, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahbl_uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .rx(rx), .IRQ(IRQ)
  );

  // ---------------- model state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  bit         m_ovr, m_ferr, m_en, m_irq_en;
  int         m_thresh, m_div;
  bit         quiet = 1'b0;

  always @(posedge HCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = exp_q.size();
    return {21'b0, 7'(n), m_ferr, m_ovr, (n == DEPTH), (n != 0)};
  endfunction

  function automatic logic model_irq();
    return m_irq_en && (exp_q.size() > m_thresh);
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_ovr = 0; m_ferr = 0; m_en = 0; m_irq_en = 0; m_thresh = 0; m_div = 0;
  endtask

  // Continuous compare whenever the model is known to be settled.
  always @(negedge HCLK) begin
    if (quiet) begin
      check("irq_level", {31'b0, IRQ}, {31'b0, model_irq()});
      check("hreadyout", {31'b0, HREADYOUT}, 32'h1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    repeat (2) @(posedge HCLK);
    quiet = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    quiet = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h4000_100, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    quiet = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h4000_100, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    bus_read(4'h4, d);
    check(name, d, model_status());
  endtask

  task automatic read_data(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    bus_read(4'h0, d);
    check(name, d, {24'b0, e});
  endtask

  // Two DATA reads with back-to-back address phases.
  task automatic read2(output logic [31:0] d0, output logic [31:0] d1);
    quiet = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4000_1000;
    @(posedge HCLK); #1;
    d0 = HRDATA;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d1 = HRDATA;
  endtask

  task automatic read2_check(input string name);
    logic [31:0] d0, d1;
    logic [7:0]  e0, e1;
    e0 = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    e1 = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    read2(d0, d1);
    check({name, "_0"}, d0, {24'b0, e0});
    check({name, "_1"}, d1, {24'b0, e1});
  endtask

  // One 8N1 frame; a bad stop bit is held low only past mid-bit, then idle.
  task automatic send_frame(input logic [7:0] b, input bit good, input int bitc);
    quiet = 1'b0;
    @(posedge HCLK); #1;
    rx = 1'b0;
    repeat (bitc) @(posedge HCLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bitc) @(posedge HCLK);
      #1;
    end
    if (good) begin
      rx = 1'b1;
      repeat (bitc) @(posedge HCLK);
    end else begin
      rx = 1'b0;
      repeat (bitc / 2 + 8) @(posedge HCLK);
      #1;
      rx = 1'b1;
      repeat (bitc - bitc / 2 - 8) @(posedge HCLK);
    end
    #1;
    rx = 1'b1;
    repeat (2 * bitc) @(posedge HCLK);
    if (m_en) begin
      if (!good) m_ferr = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (150000) @(posedge HCLK);
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d, d1;
    int          c0, lat, tries, dv, th, nrd;
    bit          found, ie, good;

    HRESET = 1'b1; rx = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0; HREADY = 1'b1; HSIZE = 3'b010;
    reset_model();
    repeat (4) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    bus_read(4'h4, d); check("rst_status", d, 32'h0);
    bus_read(4'h8, d); check("rst_div", d, 32'h0);
    bus_read(4'hC, d); check("rst_ctrl", d, 32'h0);
    bus_read(4'h0, d); check("rst_empty_data", d, 32'h0);
    settle();

    // 0xA5 at DIV=0, with start-edge to count-visible latency.
    bus_write(4'hC, 32'h1); m_en = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        wait (rx == 1'b0);
        c0 = cyc;
        found = 1'b0;
        tries = 0;
        while (!found && tries < 200) begin
          bus_read(4'h4, d);
          found = (d[10:4] == 7'd1) && d[0];
          tries++;
        end
        lat = cyc - c0;
        n_cmp++;
        if (!found || lat < 150 || lat > 160) begin
          n_err++;
          $display("FAIL a5_latency: got %0d cycles (found=%0d) expected 150..160", lat, found);
        end
      end
    join
    settle();
    check("a5_status", model_status(), 32'h11);
    check_status("a5_status_dut");
    bus_read(4'h0, d); check("a5_data", d, 32'h0000_00A5);
    void'(exp_q.pop_front());
    bus_read(4'h4, d); check("a5_status_after", d, 32'h0);
    settle();

    // Short glitch: no byte, no frame error.
    quiet = 1'b0;
    @(posedge HCLK); #1; rx = 1'b0;
    repeat (3) @(posedge HCLK);
    #1; rx = 1'b1;
    repeat (40) @(posedge HCLK);
    bus_read(4'h4, d); check("glitch_status", d, 32'h0);
    send_frame(8'hC3, 1'b1, 16);
    read_data("glitch_recover_data");
    settle();

    // Frame error, then write-1-to-clear.
    send_frame(8'h3C, 1'b0, 16);
    bus_read(4'h4, d); check("ferr_status", d, 32'h8);
    bus_write(4'h4, 32'h8); m_ferr = 1'b0;
    bus_read(4'h4, d); check("ferr_cleared", d, 32'h0);
    settle();

    // Seventeen bytes without reading: full and overrun.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 16);
    settle();
    check("full_model", model_status(), 32'h107);
    check_status("full_status");
    read2(d, d1);
    check("full_b2b_0", d, 32'h0);
    check("full_b2b_1", d1, 32'h1);
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    for (int i = 2; i < 16; i++) read_data("full_drain");
    bus_read(4'h4, d); check("drained_status", d, 32'h4);
    bus_write(4'h4, 32'h4); m_ovr = 1'b0;
    check_status("ovr_cleared");
    settle();

    // IRQ with thresh=3.
    bus_write(4'hC, 32'h33); m_irq_en = 1'b1; m_thresh = 3;
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h40 + 8'(i), 1'b1, 16);
      settle();
      @(negedge HCLK);
      check("irq_step", {31'b0, IRQ}, (i == 3) ? 32'h1 : 32'h0);
    end
    read_data("irq_pop");
    settle();
    @(negedge HCLK);
    check("irq_fell", {31'b0, IRQ}, 32'h0);
    for (int i = 0; i < 3; i++) read_data("irq_drain");
    bus_write(4'hC, 32'h1); m_irq_en = 1'b0; m_thresh = 0;
    settle();

    // DIV=3, one good byte, then reset in the middle of the next frame.
    bus_write(4'h8, 32'h3); m_div = 3;
    send_frame(8'h77, 1'b1, 64);
    check_status("div3_status");
    fork
      send_frame(8'h99, 1'b1, 64);
      begin
        repeat (64 * 4 + 34) @(posedge HCLK);
        #1; HRESET = 1'b1;
        reset_model();
        repeat (3) @(posedge HCLK);
        #1; HRESET = 1'b0;
      end
    join
    bus_read(4'h4, d); check("post_rst_status", d, 32'h0);
    bus_read(4'h8, d); check("post_rst_div", d, 32'h0);
    bus_read(4'hC, d); check("post_rst_ctrl", d, 32'h0);
    bus_write(4'hC, 32'h1); m_en = 1'b1;
    send_frame(8'h5A, 1'b1, 16);
    bus_read(4'h0, d); check("post_rst_5a", d, 32'h0000_005A);
    void'(exp_q.pop_front());
    settle();

    // Randomized frames, baud rates, reads and control writes.
    for (int it = 0; it < 40; it++) begin
      dv = $urandom_range(0, 3);
      if (dv != m_div) begin
        bus_write(4'h8, 32'(dv)); m_div = dv;
      end
      if ($urandom_range(0, 4) == 0) begin
        th = $urandom_range(0, 5);
        ie = 1'($urandom_range(0, 1));
        bus_write(4'hC, {22'b0, 6'(th), 2'b0, ie, 1'b1});
        m_thresh = th; m_irq_en = ie;
      end
      good = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom_range(0, 255)), good, (dv + 1) * 16);
      settle();
      check_status("rand_status");
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) read_data("rand_data");
      if ($urandom_range(0, 3) == 0) read2_check("rand_b2b");
      if ($urandom_range(0, 3) == 0) begin
        bus_write(4'h4, 32'hC); m_ovr = 1'b0; m_ferr = 1'b0;
      end
      settle();
    end
    while (exp_q.size() != 0) read_data("final_drain");
    check_status("final_status");
    settle();
    repeat (4) @(posedge HCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
